// File: rtl/demux_32bit_1to2_buffered.sv
// demux_32bit_1to2_buffered: routes each input word into one of two independent FIFO queues (A/B)
module demux_32bit_1to2_buffered #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [DATA_WIDTH-1:0]      inData,
  input  logic                       inSel,
  input  logic                       inValid,
  output logic                       inReady,
  output logic [DATA_WIDTH-1:0]      outA,
  output logic                       outAValid,
  input  logic                       outAReady,
  output logic [DATA_WIDTH-1:0]      outB,
  output logic                       outBValid,
  input  logic                       outBReady,
  output logic [$clog2(DEPTH):0]     levelA,
  output logic [$clog2(DEPTH):0]     levelB
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [DATA_WIDTH-1:0] head [2];
  logic [LW-1:0]         lvl  [2];
  logic [1:0]            not_full;
  logic [1:0]            out_rdy;
  assign out_rdy = {outBReady, outAReady};
  // a full queue refuses a push even when it pops on the same edge
  assign inReady = Reset_n & (inSel ? not_full[1] : not_full[0]);
  for (genvar g = 0; g < 2; g++) begin : g_q
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]         lvl_q, lvl_d;
    logic                  push, pop;
    assign push        = inValid & inReady & (inSel == 1'(g));
    assign pop         = (lvl_q != '0) & out_rdy[g];
    assign not_full[g] = lvl_q < LW'(DEPTH);
    assign lvl[g]      = lvl_q;
    assign head[g]     = (lvl_q != '0) ? mem_q[rd_q] : '0;
    // next pointers wrap naturally because DEPTH is a power of two
    always_comb begin
      wr_d  = wr_q + AW'(push);
      rd_d  = rd_q + AW'(pop);
      lvl_d = lvl_q + LW'(push) - LW'(pop);
    end
    // pointer and occupancy registers, cleared asynchronously
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        wr_q  <= '0;
        rd_q  <= '0;
        lvl_q <= '0;
      end else begin
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        lvl_q <= lvl_d;
      end
    end
    // storage needs no reset: the head is masked to zero while the queue is empty
    always_ff @(posedge Clk) begin
      if (push) mem_q[wr_q] <= inData;
    end
  end
  assign outA      = head[0];
  assign outB      = head[1];
  assign levelA    = lvl[0];
  assign levelB    = lvl[1];
  assign outAValid = lvl[0] != '0;
  assign outBValid = lvl[1] != '0;
endmodule

// File: tb/tb_demux_32bit_1to2_buffered.sv
// tb_demux_32bit_1to2_buffered: scoreboard bench with queue reference model for the buffered 1:2 demux
module tb_demux_32bit_1to2_buffered;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  logic          Clk = 0;
  logic          Reset_n = 0;
  logic [DW-1:0] inData = '0;
  logic          inSel = 0;
  logic          inValid = 0;
  logic          inReady;
  logic [DW-1:0] outA, outB;
  logic          outAValid, outBValid;
  logic          outAReady = 0, outBReady = 0;
  logic [$clog2(DEPTH):0] levelA, levelB;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic exp_rdy;
  logic rand_rdy = 0;

  demux_32bit_1to2_buffered #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .inData(inData), .inSel(inSel), .inValid(inValid),
    .inReady(inReady), .outA(outA), .outAValid(outAValid), .outAReady(outAReady),
    .outB(outB), .outBValid(outBValid), .outBReady(outBReady),
    .levelA(levelA), .levelB(levelB)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, a, e, $time);
    end
  endtask

  // monitor: compares DUT against the queue model at negedge, then applies the coming edge to the model
  always @(negedge Clk) begin
    if (!Reset_n) begin
      chk("rst_inReady", 32'(inReady), 0);
      chk("rst_levelA", 32'(levelA), 0);
      chk("rst_levelB", 32'(levelB), 0);
      chk("rst_validA", 32'(outAValid), 0);
      chk("rst_validB", 32'(outBValid), 0);
      chk("rst_outA", outA, 0);
      chk("rst_outB", outB, 0);
      qa.delete();
      qb.delete();
    end else begin
      exp_rdy = (inSel ? qb.size() : qa.size()) < DEPTH;
      chk("inReady", 32'(inReady), 32'(exp_rdy));
      chk("levelA", 32'(levelA), 32'(qa.size()));
      chk("levelB", 32'(levelB), 32'(qb.size()));
      chk("validA", 32'(outAValid), 32'(qa.size() != 0));
      chk("validB", 32'(outBValid), 32'(qb.size() != 0));
      if (qa.size() != 0) begin
        chk("outA", outA, qa[0]);
        if (outAReady) void'(qa.pop_front());
      end else chk("outA_empty", outA, 0);
      if (qb.size() != 0) begin
        chk("outB", outB, qb[0]);
        if (outBReady) void'(qb.pop_front());
      end else chk("outB_empty", outB, 0);
      if (inValid && exp_rdy) begin
        if (inSel) qb.push_back(inData);
        else qa.push_back(inData);
      end
    end
  end

  // random consumer readiness while enabled
  always @(posedge Clk) begin
    if (rand_rdy) begin
      #1;
      outAReady = 1'($urandom);
      outBReady = 1'($urandom);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic s, input logic [DW-1:0] d);
    logic acc;
    int n;
    n = 0;
    inSel = s;
    inData = d;
    inValid = 1;
    do begin
      @(negedge Clk);
      acc = inReady;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: data 0x%08h never accepted", d);
    end
    inValid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    outAReady = 1;
    outBReady = 1;
    while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    tick();
    chk("drain_done", 32'(qa.size() + qb.size()), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1;
    // single word to A held while consumer stalls
    send(0, 32'hDEADBEEF);
    repeat (3) tick();
    chk("hold_outA", outA, 32'hDEADBEEF);
    chk("hold_levelA", 32'(levelA), 1);
    outAReady = 1;
    tick();
    outAReady = 0;
    chk("popped_validA", 32'(outAValid), 0);
    // fill B, third push refused, A still open
    send(1, 32'h1);
    send(1, 32'h2);
    chk("fullB_level", 32'(levelB), 2);
    inSel = 1;
    inValid = 1;
    inData = 32'h3;
    #2;
    chk("fullB_inReady_sel1", 32'(inReady), 0);
    inSel = 0;
    #1;
    chk("fullB_inReady_sel0", 32'(inReady), 1);
    inSel = 1;
    // pop with refused push on the same edge, then push lands after
    outBReady = 1;
    tick();
    outBReady = 0;
    chk("pop_only_levelB", 32'(levelB), 1);
    chk("pop_only_outB", outB, 32'h2);
    tick();
    inValid = 0;
    chk("refill_levelB", 32'(levelB), 2);
    drain();
    // alternating random traffic with random consumers
    rand_rdy = 1;
    for (int i = 0; i < 100; i++) send(1'(i), DW'(i));
    rand_rdy = 0;
    drain();
    // asynchronous reset mid-cycle discards content
    outAReady = 0;
    outBReady = 0;
    send(0, 32'hA);
    send(1, 32'hB1);
    send(1, 32'hB2);
    chk("pre_rst_levelA", 32'(levelA), 1);
    chk("pre_rst_levelB", 32'(levelB), 2);
    #2;
    Reset_n = 0;
    #1;
    chk("async_levelA", 32'(levelA), 0);
    chk("async_levelB", 32'(levelB), 0);
    chk("async_validA", 32'(outAValid), 0);
    chk("async_validB", 32'(outBValid), 0);
    chk("async_outA", outA, 0);
    chk("async_outB", outB, 0);
    chk("async_inReady", 32'(inReady), 0);
    tick();
    tick();
    Reset_n = 1;
    send(1, 32'h55);
    chk("post_rst_outB", outB, 32'h55);
    chk("post_rst_levelB", 32'(levelB), 1);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
